// File: rtl/segre_mem_arbiter_pkg.sv
// Shared types and constants for the memory-request arbiter.
// arb_req_t generalises the two-cache request record to N requesters by
// carrying a generic port id instead of a cache id.
package segre_mem_arbiter_pkg;

    localparam int NUM_MEM_PORTS         = 2;
    localparam int ARB_BUF_SIZE          = 16;
    localparam int ARB_PTR_SIZE          = $clog2(ARB_BUF_SIZE);
    localparam int ADDR_SIZE             = 32;
    localparam int CACHE_LINE_SIZE_BYTES = 16;
    localparam int CACHE_LINE_W          = CACHE_LINE_SIZE_BYTES * 8;

    // The id field is sized for the largest supported port count so that one
    // struct type serves every arbiter configuration; memory echoes it back.
    localparam int ARB_MAX_PORTS = 16;
    localparam int ARB_ID_W      = $clog2(ARB_MAX_PORTS);

    typedef struct packed {
        logic [ARB_ID_W-1:0]     id;
        logic                    rd;
        logic                    wr;
        logic [ADDR_SIZE-1:0]    addr;
        logic [CACHE_LINE_W-1:0] line;
    } arb_req_t;

endpackage

// File: rtl/segre_mem_arbiter_sync_fifo.sv
// Single-clock FIFO with occupancy count. The head output is zero whenever
// the FIFO is empty so stale storage never leaks onto the memory bus.
module segre_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [PTR_W-1:0]            wr_ptr_q;
    logic [PTR_W-1:0]            rd_ptr_q;
    logic [CNT_W-1:0]            count_q;

    // Storage write; no reset needed since reads are gated by empty.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/segre_mem_arbiter.sv
// N-port memory-request arbiter: grants one requester per cycle into a shared
// FIFO, issues the FIFO head to memory, and demuxes responses by port id.
// Build option: define SEGRE_ARB_RR_EN for round-robin priority; otherwise
// fixed priority with the lowest port index winning.
module segre_mem_arbiter
    import segre_mem_arbiter_pkg::*;
#(
    parameter int NUM_PORTS  = NUM_MEM_PORTS,
    parameter int BUF_DEPTH  = ARB_BUF_SIZE,
    parameter int ADDR_W     = ADDR_SIZE,
    parameter int LINE_BYTES = CACHE_LINE_SIZE_BYTES
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NUM_PORTS-1:0]                   req_valid_i,
    output logic [NUM_PORTS-1:0]                   req_ready_o,
    input  logic [NUM_PORTS-1:0]                   req_rd_i,
    input  logic [NUM_PORTS-1:0]                   req_wr_i,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]       req_addr_i,
    input  logic [NUM_PORTS-1:0][LINE_BYTES*8-1:0] req_line_i,
    output logic                                   mem_valid_o,
    input  logic                                   mem_ready_i,
    output arb_req_t                               mem_req_o,
    input  logic                                   mem_rsp_valid_i,
    input  logic [ARB_ID_W-1:0]                    mem_rsp_id_i,
    input  logic [LINE_BYTES*8-1:0]                mem_rsp_line_i,
    output logic [NUM_PORTS-1:0]                   rsp_valid_o,
    output logic [LINE_BYTES*8-1:0]                rsp_line_o,
    output logic [$clog2(BUF_DEPTH):0]             count_o,
    output logic                                   full_o,
    output logic                                   empty_o
);

    localparam int ID_W  = $clog2(NUM_PORTS);
    localparam int REQ_W = $bits(arb_req_t);

    logic             found;
    logic             gnt_any;
    logic [ID_W-1:0]  gnt_id;
    arb_req_t         push_req;
    logic [REQ_W-1:0] head;
    logic             pop;

`ifdef SEGRE_ARB_RR_EN
    logic [ID_W-1:0] rr_q;
    logic [ID_W-1:0] idx;

    // Round-robin search starting at rr_q, wrapping modulo NUM_PORTS.
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        idx    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = ID_W'((int'(rr_q) + i) % NUM_PORTS);
            if (!found && req_valid_i[idx]) begin
                found  = 1'b1;
                gnt_id = idx;
            end
        end
    end

    // Advance the pointer past the winner; hold it when nothing is granted.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            rr_q <= '0;
        else if (gnt_any)
            rr_q <= (gnt_id == ID_W'(NUM_PORTS - 1)) ? '0 : gnt_id + 1'b1;
    end
`else
    // Fixed priority: the lowest valid index wins.
    always_comb begin
        found  = |req_valid_i;
        gnt_id = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_valid_i[i]) gnt_id = ID_W'(i);
        end
    end
`endif

    // No grant while full, even if the head pops this cycle, and none in reset.
    assign gnt_any = found && !full_o && !rst_i;

    // One-hot grant strobe back to the winning requester.
    always_comb begin
        req_ready_o = '0;
        if (gnt_any) req_ready_o[gnt_id] = 1'b1;
    end

    // Capture the winner's payload with its port id for the FIFO.
    always_comb begin
        push_req      = '0;
        push_req.id   = ARB_ID_W'(gnt_id);
        push_req.rd   = req_rd_i[gnt_id];
        push_req.wr   = req_wr_i[gnt_id];
        push_req.addr = ADDR_SIZE'(req_addr_i[gnt_id]);
        push_req.line = CACHE_LINE_W'(req_line_i[gnt_id]);
    end

    assign pop = mem_valid_o && mem_ready_i;

    segre_sync_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (gnt_any),
        .data_i  (push_req),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full_o),
        .empty_o (empty_o),
        .count_o (count_o)
    );

    assign mem_valid_o = !empty_o;
    assign mem_req_o   = head;

    // Response demux: ids outside the port range strobe nothing.
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_rsp
        assign rsp_valid_o[g] = !rst_i && mem_rsp_valid_i && (mem_rsp_id_i == ARB_ID_W'(g));
    end
    assign rsp_line_o = mem_rsp_line_i;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Directed bench for segre_mem_arbiter with four ports and a 16-deep FIFO.
// Grant-order expectations follow SEGRE_ARB_RR_EN when it is defined.
module tb_segre_mem_arbiter;
    import segre_mem_arbiter_pkg::*;

    localparam int NP    = 4;
    localparam int DEPTH = 16;
    localparam int AW    = 32;
    localparam int LB    = 16;
    localparam int LW    = LB * 8;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic [NP-1:0]          req_valid_i;
    logic [NP-1:0]          req_ready_o;
    logic [NP-1:0]          req_rd_i;
    logic [NP-1:0]          req_wr_i;
    logic [NP-1:0][AW-1:0]  req_addr_i;
    logic [NP-1:0][LW-1:0]  req_line_i;
    logic                   mem_valid_o;
    logic                   mem_ready_i;
    arb_req_t               mem_req_o;
    logic                   mem_rsp_valid_i;
    logic [ARB_ID_W-1:0]    mem_rsp_id_i;
    logic [LW-1:0]          mem_rsp_line_i;
    logic [NP-1:0]          rsp_valid_o;
    logic [LW-1:0]          rsp_line_o;
    logic [$clog2(DEPTH):0] count_o;
    logic                   full_o;
    logic                   empty_o;

    int passed = 0;
    int total  = 0;

    segre_mem_arbiter #(
        .NUM_PORTS  (NP),
        .BUF_DEPTH  (DEPTH),
        .ADDR_W     (AW),
        .LINE_BYTES (LB)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_rd_i        (req_rd_i),
        .req_wr_i        (req_wr_i),
        .req_addr_i      (req_addr_i),
        .req_line_i      (req_line_i),
        .mem_valid_o     (mem_valid_o),
        .mem_ready_i     (mem_ready_i),
        .mem_req_o       (mem_req_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_id_i    (mem_rsp_id_i),
        .mem_rsp_line_i  (mem_rsp_line_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_line_o      (rsp_line_o),
        .count_o         (count_o),
        .full_o          (full_o),
        .empty_o         (empty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        req_valid_i = '0;
        mem_ready_i = 1'b0;
        step();
        rst_i = 1'b0;
    endtask

    initial begin
        int exp_port;
        int prev_port;
        logic [LW-1:0] line_k;

        rst_i           = 1'b1;
        req_valid_i     = '0;
        req_rd_i        = '0;
        req_wr_i        = '0;
        req_addr_i      = '0;
        req_line_i      = '0;
        mem_ready_i     = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_id_i    = '0;
        mem_rsp_line_i  = '0;

        // ---- reset: no grant and no response strobe while rst_i is high
        step();
        req_valid_i     = 4'hF;
        mem_rsp_valid_i = 1'b1;
        #1;
        chk("rst_ready", req_ready_o, 4'b0000);
        chk("rst_rsp", rsp_valid_o, 4'b0000);
        step();
        rst_i           = 1'b0;
        req_valid_i     = '0;
        mem_rsp_valid_i = 1'b0;
        #1;
        chk("rst_count", count_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_mvalid", mem_valid_o, 0);
        chk("rst_mreq", mem_req_o, 0);

        // ---- single request from port 1
        req_valid_i   = 4'b0010;
        req_rd_i      = 4'b0010;
        req_addr_i[1] = 32'h1000;
        #1;
        chk("single_ready", req_ready_o, 4'b0010);
        chk("single_nobypass", mem_valid_o, 0);
        step();
        req_valid_i = '0;
        req_rd_i    = '0;
        #1;
        chk("single_mvalid", mem_valid_o, 1);
        chk("single_id", mem_req_o.id, 1);
        chk("single_rd", mem_req_o.rd, 1);
        chk("single_wr", mem_req_o.wr, 0);
        chk("single_addr", mem_req_o.addr, 32'h1000);
        chk("single_count", count_o, 1);
        mem_ready_i = 1'b1;
        step();
        mem_ready_i = 1'b0;
        #1;
        chk("single_empty", empty_o, 1);

        // ---- fairness: all ports valid, memory always ready
        do_reset();
        for (int p = 0; p < NP; p++) req_addr_i[p] = 32'h100 * p;
        req_valid_i = 4'hF;
        mem_ready_i = 1'b1;
        prev_port   = 0;
        for (int i = 0; i < 8; i++) begin
`ifdef SEGRE_ARB_RR_EN
            exp_port = i % NP;
`else
            exp_port = 0;
`endif
            #1;
            chk("fair_grant", req_ready_o, 256'(1) << exp_port);
            if (i > 0) chk("fair_head_id", mem_req_o.id, prev_port);
            prev_port = exp_port;
            step();
        end
        req_valid_i = '0;
        #1;
        chk("fair_last_id", mem_req_o.id, prev_port);
        chk("fair_last_addr", mem_req_o.addr, 32'h100 * prev_port);
        step();
        mem_ready_i = 1'b0;
        #1;
        chk("fair_drained", empty_o, 1);

        // ---- full boundary: 16 pushes with memory stalled, rd = wr = 0
        req_valid_i = 4'b0100;
        for (int k = 0; k < DEPTH; k++) begin
            req_addr_i[2] = 32'h2000 + k;
            step();
        end
        req_addr_i[2] = 32'h2010;
        #1;
        chk("full_count", count_o, 16);
        chk("full_flag", full_o, 1);
        chk("full_ready", req_ready_o, 4'b0000);
        chk("full_head_addr", mem_req_o.addr, 32'h2000);
        chk("full_head_rdwr", {mem_req_o.rd, mem_req_o.wr}, 2'b00);
        mem_ready_i = 1'b1;
        #1;
        chk("full_pop_ready", req_ready_o, 4'b0000);
        step();
        chk("full_after_count", count_o, 15);
        chk("full_after_flag", full_o, 0);
        chk("full_resume", req_ready_o, 4'b0100);
        step();
        req_valid_i = '0;
        #1;
        chk("full_pp_count", count_o, 15);
        for (int k = 2; k <= 16; k++) begin
            chk("full_drain_addr", mem_req_o.addr, 32'h2000 + k);
            step();
        end
        chk("full_drain_empty", empty_o, 1);

        // ---- wrap-around: 40 push/pop pairs from port 3
        mem_ready_i = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            if (k < 40) begin
                req_valid_i   = 4'b1000;
                req_addr_i[3] = 32'h3000 + k;
                req_line_i[3] = {4{32'hDEAD0000 + k}};
            end else begin
                req_valid_i = '0;
            end
            #1;
            if (k > 0) begin
                line_k = {4{32'hDEAD0000 + k - 1}};
                chk("wrap_addr", mem_req_o.addr, 32'h3000 + k - 1);
                chk("wrap_line", mem_req_o.line, line_k);
            end
            step();
        end
        mem_ready_i = 1'b0;
        chk("wrap_empty", empty_o, 1);

        // ---- response routing
        mem_rsp_valid_i = 1'b1;
        mem_rsp_id_i    = 4'd2;
        mem_rsp_line_i  = {16{8'hA5}};
        #1;
        chk("rsp_id2", rsp_valid_o, 4'b0100);
        chk("rsp_line", rsp_line_o, {16{8'hA5}});
        mem_rsp_id_i = 4'd5;
        #1;
        chk("rsp_id5", rsp_valid_o, 4'b0000);
        mem_rsp_id_i    = 4'd3;
        mem_rsp_valid_i = 1'b0;
        #1;
        chk("rsp_novalid", rsp_valid_o, 4'b0000);

        // ---- reset mid-stream: 5 entries queued from port 1
        req_valid_i = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            req_addr_i[1] = 32'h5000 + k;
            step();
        end
        req_valid_i = '0;
        #1;
        chk("mid_count5", count_o, 5);
        rst_i           = 1'b1;
        mem_rsp_valid_i = 1'b1;
        mem_rsp_id_i    = 4'd1;
        #1;
        chk("mid_rsp_drop", rsp_valid_o, 4'b0000);
        step();
        rst_i           = 1'b0;
        mem_rsp_valid_i = 1'b0;
        #1;
        chk("mid_count", count_o, 0);
        chk("mid_mvalid", mem_valid_o, 0);
        chk("mid_mreq", mem_req_o, 0);
        req_valid_i = 4'hF;
        #1;
        chk("mid_rr_reset", req_ready_o, 4'b0001);
        req_valid_i = '0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
